// File: rtl/bus_grab.sv
// Z80 bus-grab controller: requests the Z80 bus, hands it to the host once BUSACK settles,
// and runs single host read/write memory cycles with timed MREQ/RD/WR strobes.
module bus_grab #(
    parameter int unsigned SETTLE_CYC  = 2,
    parameter int unsigned STROBE_CYC  = 3,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        host_req,
    output logic        host_gnt,
    output logic        host_err,
    input  logic        cyc_start,
    input  logic        cyc_we,
    input  logic [15:0] cyc_addr,
    input  logic [7:0]  cyc_wdata,
    output logic [7:0]  cyc_rdata,
    output logic        cyc_done,
    output logic        z80_busrq_n,
    input  logic        z80_busack_n,
    output logic        bsrq,
    output logic [15:0] a_out,
    output logic [7:0]  d_out,
    input  logic [7:0]  d_in,
    output logic        d_oe,
    output logic        mreq_n,
    output logic        rd_n,
    output logic        wr_n
);

    localparam int unsigned MAX_AB  = (SETTLE_CYC > STROBE_CYC) ? SETTLE_CYC : STROBE_CYC;
    localparam int unsigned MAX_CYC = (TIMEOUT_CYC > MAX_AB) ? TIMEOUT_CYC : MAX_AB;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_REQ,
        ST_SETTLE,
        ST_OWN,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RELEASE,
        ST_ERR
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ack_s1;
    logic             r_ack_s2;
    logic             r_we;
    logic             r_host_gnt;
    logic             r_host_err;
    logic [7:0]       r_rdata;
    logic             r_cyc_done;
    logic             r_busrq_n;
    logic             r_bsrq;
    logic [15:0]      r_a_out;
    logic [7:0]       r_d_out;
    logic             r_d_oe;
    logic             r_mreq_n;
    logic             r_rd_n;
    logic             r_wr_n;
    logic             w_ack_n;

    assign w_ack_n = r_ack_s2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_ack_s1   <= 1'b1;
            r_ack_s2   <= 1'b1;
            r_we       <= 1'b0;
            r_host_gnt <= 1'b0;
            r_host_err <= 1'b0;
            r_rdata    <= '0;
            r_cyc_done <= 1'b0;
            r_busrq_n  <= 1'b1;
            r_bsrq     <= 1'b1;
            r_a_out    <= '0;
            r_d_out    <= '0;
            r_d_oe     <= 1'b0;
            r_mreq_n   <= 1'b1;
            r_rd_n     <= 1'b1;
            r_wr_n     <= 1'b1;
        end else begin
            r_ack_s1   <= z80_busack_n;
            r_ack_s2   <= r_ack_s1;
            r_cyc_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (host_req) begin
                        r_state    <= ST_REQ;
                        r_busrq_n  <= 1'b0;
                        r_cnt      <= '0;
                        r_host_err <= 1'b0;
                    end
                end

                // Acknowledge wins over a simultaneous host drop; the bus is then handed over and released from OWN.
                ST_REQ: begin
                    if (!w_ack_n) begin
                        r_state  <= ST_SETTLE;
                        r_bsrq   <= 1'b0;
                        r_mreq_n <= 1'b1;
                        r_rd_n   <= 1'b1;
                        r_wr_n   <= 1'b1;
                        r_cnt    <= '0;
                    end else if (!host_req) begin
                        r_state <= ST_RELEASE;
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        r_state    <= ST_ERR;
                        r_busrq_n  <= 1'b1;
                        r_host_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                ST_SETTLE: begin
                    if (r_cnt == CNT_W'(SETTLE_CYC - 1)) begin
                        r_state    <= ST_OWN;
                        r_host_gnt <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                ST_OWN: begin
                    if (cyc_start) begin
                        r_state <= ST_SETUP;
                        r_we    <= cyc_we;
                        r_a_out <= cyc_addr;
                        r_d_oe  <= cyc_we;
                        if (cyc_we) begin
                            r_d_out <= cyc_wdata;
                        end
                    end else if (!host_req) begin
                        r_state    <= ST_RELEASE;
                        r_host_gnt <= 1'b0;
                        r_bsrq     <= 1'b1;
                        r_d_oe     <= 1'b0;
                        r_mreq_n   <= 1'b1;
                        r_rd_n     <= 1'b1;
                        r_wr_n     <= 1'b1;
                    end
                end

                ST_SETUP: begin
                    r_state  <= ST_STROBE;
                    r_mreq_n <= 1'b0;
                    r_rd_n   <= r_we;
                    r_wr_n   <= ~r_we;
                    r_cnt    <= '0;
                end

                // Read data is captured on the edge that closes the last strobe clock.
                ST_STROBE: begin
                    if (r_cnt == CNT_W'(STROBE_CYC - 1)) begin
                        r_state  <= ST_HOLD;
                        r_mreq_n <= 1'b1;
                        r_rd_n   <= 1'b1;
                        r_wr_n   <= 1'b1;
                        if (!r_we) begin
                            r_rdata <= d_in;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                ST_HOLD: begin
                    r_state    <= ST_OWN;
                    r_cyc_done <= 1'b1;
                    r_d_oe     <= 1'b0;
                end

                ST_RELEASE: begin
                    r_state   <= ST_IDLE;
                    r_busrq_n <= 1'b1;
                end

                ST_ERR: begin
                    if (!host_req) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign host_gnt    = r_host_gnt;
    assign host_err    = r_host_err;
    assign cyc_rdata   = r_rdata;
    assign cyc_done    = r_cyc_done;
    assign z80_busrq_n = r_busrq_n;
    assign bsrq        = r_bsrq;
    assign a_out       = r_a_out;
    assign d_out       = r_d_out;
    assign d_oe        = r_d_oe;
    assign mreq_n      = r_mreq_n;
    assign rd_n        = r_rd_n;
    assign wr_n        = r_wr_n;

endmodule

// File: tb/tb_bus_grab.sv
// Bench for bus_grab: directed grant/cycle/timeout/reset steps plus randomized memory traffic
// checked against an associative reference memory and a bus-attached SRAM model.
module tb_bus_grab;

    localparam int unsigned SETTLE = 2;
    localparam int unsigned STROBE = 3;
    localparam int unsigned TMO    = 1023;
    localparam int unsigned SYNC   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        host_req = 1'b0;
    logic        cyc_start = 1'b0;
    logic        cyc_we = 1'b0;
    logic [15:0] cyc_addr = '0;
    logic [7:0]  cyc_wdata = '0;
    logic        z80_busack_n = 1'b1;
    logic [7:0]  d_in;
    logic        host_gnt, host_err, cyc_done, z80_busrq_n, bsrq, d_oe, mreq_n, rd_n, wr_n;
    logic [7:0]  cyc_rdata, d_out;
    logic [15:0] a_out;

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;

    logic [7:0]  sram [65536];
    bit          sram_vld [65536];
    logic [7:0]  ref_mem [logic [15:0]];
    logic [15:0] pool [8];

    bus_grab #(
        .SETTLE_CYC (SETTLE),
        .STROBE_CYC (STROBE),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .host_req    (host_req),
        .host_gnt    (host_gnt),
        .host_err    (host_err),
        .cyc_start   (cyc_start),
        .cyc_we      (cyc_we),
        .cyc_addr    (cyc_addr),
        .cyc_wdata   (cyc_wdata),
        .cyc_rdata   (cyc_rdata),
        .cyc_done    (cyc_done),
        .z80_busrq_n (z80_busrq_n),
        .z80_busack_n(z80_busack_n),
        .bsrq        (bsrq),
        .a_out       (a_out),
        .d_out       (d_out),
        .d_in        (d_in),
        .d_oe        (d_oe),
        .mreq_n      (mreq_n),
        .rd_n        (rd_n),
        .wr_n        (wr_n)
    );

    always #5 clk = ~clk;

    // Power-up content of the external memory; 0x0100 holds 0x3C.
    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3D;
    endfunction

    assign d_in = sram_vld[a_out] ? sram[a_out] : init_val(a_out);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus rules every clock, and the SRAM stores whatever a write strobe presents.
    always @(negedge clk) begin
        logic ok;
        ok = !(bsrq && (!mreq_n || !rd_n || !wr_n)) && !(!rd_n && !wr_n)
             && !(d_oe && !rd_n) && !(!wr_n && !d_oe);
        check("bus_rules", ok, 1);
        if (reset && !mreq_n && !wr_n) begin
            sram[a_out]     = d_out;
            sram_vld[a_out] = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic grab(input int unsigned ack_dly);
        int unsigned t_bsrq, t_gnt;
        host_req = 1'b1;
        tick();
        check("grab_busrq_n", z80_busrq_n, 0);
        check("grab_no_gnt", host_gnt, 0);
        repeat (ack_dly) tick();
        z80_busack_n = 1'b0;
        t_bsrq = 0;
        t_gnt  = 0;
        for (int unsigned t = 1; t <= 30 && t_gnt == 0; t++) begin
            tick();
            if (t_bsrq == 0 && !bsrq) t_bsrq = t;
            if (host_gnt) t_gnt = t;
        end
        check("grab_bsrq_lat", t_bsrq, SYNC + 1);
        check("grab_gnt_lat", t_gnt, SYNC + 1 + SETTLE);
        check("grab_bsrq_own", bsrq, 0);
    endtask

    task automatic release_bus();
        host_req = 1'b0;
        tick();
        check("rel_gnt", host_gnt, 0);
        check("rel_bsrq", bsrq, 1);
        check("rel_busrq_hold", z80_busrq_n, 0);
        tick();
        check("rel_busrq", z80_busrq_n, 1);
        z80_busack_n = 1'b1;
        repeat (4) tick();
    endtask

    // drop: 0 keep host_req, 1 drop with cyc_start, 2 drop one clock later.
    task automatic do_cycle(input bit we, input logic [15:0] addr, input logic [7:0] wdata,
                            input int unsigned drop);
        int unsigned t_done, n_done, n_low, t_first, n_oe;
        logic [7:0]  exp_rd;
        exp_rd  = ref_mem.exists(addr) ? ref_mem[addr] : init_val(addr);
        t_done  = 0;
        n_done  = 0;
        n_low   = 0;
        t_first = 0;
        n_oe    = 0;
        cyc_start = 1'b1;
        cyc_we    = we;
        cyc_addr  = addr;
        cyc_wdata = wdata;
        if (drop == 1) host_req = 1'b0;
        tick();
        cyc_start = 1'b0;
        cyc_we    = 1'($urandom);
        cyc_addr  = 16'($urandom);
        cyc_wdata = 8'($urandom);
        if (drop == 2) host_req = 1'b0;
        check("setup_addr", a_out, addr);
        check("setup_oe", d_oe, we);
        if (we) check("setup_data", d_out, wdata);
        check("setup_mreq", mreq_n, 1);
        for (int unsigned t = 2; t <= 12; t++) begin
            tick();
            if (!mreq_n) begin
                n_low++;
                if (t_first == 0) t_first = t;
                check("strobe_kind", {rd_n, wr_n}, we ? 2'b10 : 2'b01);
            end
            if (d_oe) n_oe++;
            if (cyc_done) begin
                n_done++;
                if (t_done == 0) begin
                    t_done = t;
                    if (!we) check("rdata", cyc_rdata, exp_rd);
                    check("done_doe", d_oe, 0);
                end
            end
        end
        check("strobe_len", n_low, STROBE);
        check("strobe_first", t_first, 2);
        check("done_lat", t_done, STROBE + 3);
        check("done_pulses", n_done, 1);
        check("oe_cycles", n_oe, we ? STROBE + 1 : 0);
        if (we) begin
            ref_mem[addr] = wdata;
            check("sram_wr", sram[addr], wdata);
        end
        if (drop != 0) begin
            check("drop_gnt", host_gnt, 0);
            check("drop_bsrq", bsrq, 1);
            check("drop_busrq", z80_busrq_n, 1);
            z80_busack_n = 1'b1;
            repeat (4) tick();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t_err, n_bad;
        logic [15:0] a_prev;
        bit          we;
        logic [15:0] addr;
        logic [7:0]  wd;
        int unsigned drop;

        for (int i = 0; i < 8; i++) pool[i] = {1'b1, 15'($urandom)};

        #2 reset = 1'b0;
        #2;
        check("rst_busrq", z80_busrq_n, 1);
        check("rst_bsrq", bsrq, 1);
        check("rst_gnt", host_gnt, 0);
        check("rst_err", host_err, 0);
        check("rst_done", cyc_done, 0);
        check("rst_oe", d_oe, 0);
        check("rst_strobes", {mreq_n, rd_n, wr_n}, 3'b111);
        check("rst_addr", a_out, 0);
        check("rst_dout", d_out, 0);
        check("rst_rdata", cyc_rdata, 0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();

        grab(2);
        do_cycle(1'b1, 16'h1234, 8'hA5, 0);
        do_cycle(1'b0, 16'h0100, 8'h00, 0);
        check("dir_rd_3c", cyc_rdata, 8'h3C);
        do_cycle(1'b0, 16'h1234, 8'h00, 0);
        release_bus();

        // cyc_start while idle must not start a cycle
        a_prev    = a_out;
        cyc_start = 1'b1;
        cyc_we    = 1'b1;
        cyc_addr  = 16'hBEEF;
        cyc_wdata = 8'h77;
        tick();
        cyc_start = 1'b0;
        n_bad = 0;
        repeat (8) begin
            tick();
            if (cyc_done || !mreq_n) n_bad++;
        end
        check("idle_ign_act", n_bad, 0);
        check("idle_ign_addr", a_out, a_prev);

        // BUSACK never arrives
        host_req = 1'b1;
        tick();
        check("tmo_busrq", z80_busrq_n, 0);
        t_err = 0;
        for (int unsigned t = 1; t <= 1100 && t_err == 0; t++) begin
            tick();
            if (host_err) t_err = t;
        end
        check("tmo_lat", t_err, TMO);
        check("tmo_busrq_rel", z80_busrq_n, 1);
        check("tmo_gnt", host_gnt, 0);
        host_req = 1'b0;
        tick();
        check("tmo_sticky1", host_err, 1);
        tick();
        check("tmo_sticky2", host_err, 1);
        host_req = 1'b1;
        tick();
        check("tmo_clear", host_err, 0);
        check("tmo_rereq", z80_busrq_n, 0);
        host_req = 1'b0;
        repeat (2) tick();
        check("req_abort", z80_busrq_n, 1);
        repeat (3) tick();

        grab(0);
        do_cycle(1'b1, pool[0], 8'h5E, 2);
        grab(1);
        do_cycle(1'b0, pool[0], 8'h00, 1);
        grab(3);

        for (int i = 0; i < 24; i++) begin
            we   = 1'($urandom);
            addr = pool[$urandom_range(0, 7)];
            wd   = 8'($urandom);
            drop = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
            do_cycle(we, addr, wd, drop);
            if (drop != 0) begin
                grab($urandom_range(0, 4));
            end else if ($urandom_range(0, 4) == 0) begin
                release_bus();
                grab($urandom_range(0, 4));
            end else begin
                repeat ($urandom_range(0, 2)) tick();
            end
        end

        // reset in the middle of a write strobe
        cyc_start = 1'b1;
        cyc_we    = 1'b1;
        cyc_addr  = 16'h4321;
        cyc_wdata = 8'h5A;
        tick();
        cyc_start = 1'b0;
        tick();
        check("mid_pre_mreq", mreq_n, 0);
        #2 reset = 1'b0;
        #1;
        check("mid_mreq", mreq_n, 1);
        check("mid_wr", wr_n, 1);
        check("mid_bsrq", bsrq, 1);
        check("mid_busrq", z80_busrq_n, 1);
        check("mid_gnt", host_gnt, 0);
        host_req     = 1'b0;
        z80_busack_n = 1'b1;
        n_bad = 0;
        repeat (4) begin
            tick();
            if (cyc_done) n_bad++;
        end
        reset = 1'b1;
        repeat (2) begin
            tick();
            if (cyc_done) n_bad++;
        end
        check("mid_no_done", n_bad, 0);

        grab(0);
        do_cycle(1'b0, pool[1], 8'h00, 0);
        release_bus();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
